// File: rtl/split_target_pkg.sv
`default_nettype none
// ============================================================================
// Module   : split_target_pkg
// Brief    : Shared widths and core FSM state encoding for split_target.
// Revision : 1.0
// ============================================================================
package split_target_pkg;

  localparam int c_addr_width = 16;
  localparam int c_data_width = 8;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_DATA = 3'd1,
    S_WRITE     = 3'd2,
    S_READ_WAIT = 3'd3,
    S_SPLIT_REQ = 3'd4,
    S_SEND      = 3'd5
  } state_t;

endpackage
`default_nettype wire

// File: rtl/split_target_if.sv
`default_nettype none
// ============================================================================
// Module   : split_target_if
// Brief    : Serial system-bus and arbiter signals seen by a split target.
// Revision : 1.0
// ============================================================================
interface split_target_if;
  import split_target_pkg::*;

  logic                    decoder_valid;
  logic                    bus_data_in;
  logic                    bus_data_in_valid;
  logic                    bus_mode;
  logic                    s_rw;
  logic                    split_grant;
  logic                    bus_data_out;
  logic                    bus_data_out_valid;
  logic                    arbiter_split_req;
  logic                    split_ack;
  logic                    bus_split_ack;
  logic                    bus_s_ack;
  logic                    bus_s_ready;
  logic                    bus_s_rw;
  logic [c_data_width-1:0] last_write;

  modport slave (
    input  decoder_valid, bus_data_in, bus_data_in_valid, bus_mode, s_rw, split_grant,
    output bus_data_out, bus_data_out_valid, arbiter_split_req, split_ack,
           bus_split_ack, bus_s_ack, bus_s_ready, bus_s_rw, last_write
  );

  modport master (
    output decoder_valid, bus_data_in, bus_data_in_valid, bus_mode, s_rw, split_grant,
    input  bus_data_out, bus_data_out_valid, arbiter_split_req, split_ack,
           bus_split_ack, bus_s_ack, bus_s_ready, bus_s_rw, last_write
  );

endinterface
`default_nettype wire

// File: rtl/split_target_port.sv
`default_nettype none
// ============================================================================
// Module   : split_target_port
// Brief    : Serial deserializer/serializer between the bus and the target core.
// Revision : 1.0
// ============================================================================
module split_target_port
  import split_target_pkg::*;
#(
  parameter int ADDR_WIDTH = c_addr_width,
  parameter int DATA_WIDTH = c_data_width
) (
  input  wire logic                  clk,
  input  wire logic                  rst_n,
  split_target_if.slave              bus,
  input  wire logic                  i_ready,
  input  wire logic                  i_wr_ack,
  input  wire logic                  i_split_ack,
  input  wire logic                  i_split_req,
  input  wire logic                  i_tx_load,
  input  wire logic [DATA_WIDTH-1:0] i_tx_data,
  input  wire logic [DATA_WIDTH-1:0] i_last_write,
  output logic      [ADDR_WIDTH-1:0] o_addr,
  output logic                       o_addr_valid,
  output logic      [DATA_WIDTH-1:0] o_data,
  output logic                       o_data_valid,
  output logic                       o_tx_done
);

  localparam int c_acnt_w = $clog2(ADDR_WIDTH);
  localparam int c_dcnt_w = $clog2(DATA_WIDTH);
  localparam logic [c_acnt_w-1:0] c_acnt_max = c_acnt_w'(ADDR_WIDTH - 1);
  localparam logic [c_dcnt_w-1:0] c_dcnt_max = c_dcnt_w'(DATA_WIDTH - 1);

  logic [ADDR_WIDTH-1:0] r_addr;
  logic [c_acnt_w-1:0]   r_acnt;
  logic                  r_addr_valid;
  logic [DATA_WIDTH-1:0] r_data;
  logic [c_dcnt_w-1:0]   r_dcnt;
  logic                  r_data_valid;
  logic [DATA_WIDTH-1:0] r_sh;
  logic [c_dcnt_w-1:0]   r_tcnt;
  logic                  r_out;
  logic                  r_out_v;
  logic                  r_tx_ack;
  logic                  w_accept;

  assign w_accept = bus.bus_data_in_valid && bus.decoder_valid && i_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr       <= '0;
      r_acnt       <= '0;
      r_addr_valid <= 1'b0;
      r_data       <= '0;
      r_dcnt       <= '0;
      r_data_valid <= 1'b0;
    end else begin
      r_addr_valid <= 1'b0;
      r_data_valid <= 1'b0;
      if (!bus.decoder_valid) begin
        r_acnt <= '0;
        r_dcnt <= '0;
      end else if (w_accept) begin
        if (!bus.bus_mode) begin
          r_addr[r_acnt] <= bus.bus_data_in;
          if (r_acnt == c_acnt_max) begin
            r_acnt       <= '0;
            r_addr_valid <= 1'b1;
          end else begin
            r_acnt <= r_acnt + 1'b1;
          end
        end else begin
          r_data[r_dcnt] <= bus.bus_data_in;
          if (r_dcnt == c_dcnt_max) begin
            r_dcnt       <= '0;
            r_data_valid <= 1'b1;
          end else begin
            r_dcnt <= r_dcnt + 1'b1;
          end
        end
      end
    end
  end

  // Read ack is raised together with the last serial bit so both share a cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh     <= '0;
      r_tcnt   <= '0;
      r_out    <= 1'b0;
      r_out_v  <= 1'b0;
      r_tx_ack <= 1'b0;
    end else if (i_tx_load) begin
      r_sh     <= i_tx_data;
      r_out    <= i_tx_data[0];
      r_out_v  <= 1'b1;
      r_tcnt   <= '0;
      r_tx_ack <= 1'b0;
    end else if (r_out_v) begin
      if (r_tcnt == c_dcnt_max) begin
        r_out_v  <= 1'b0;
        r_out    <= 1'b0;
        r_tx_ack <= 1'b0;
      end else begin
        r_sh     <= {1'b0, r_sh[DATA_WIDTH-1:1]};
        r_out    <= r_sh[1];
        r_tcnt   <= r_tcnt + 1'b1;
        r_tx_ack <= (r_tcnt == c_dcnt_max - 1'b1);
      end
    end
  end

  assign o_addr       = r_addr;
  assign o_addr_valid = r_addr_valid;
  assign o_data       = r_data;
  assign o_data_valid = r_data_valid;
  assign o_tx_done    = r_out_v && (r_tcnt == c_dcnt_max);

  assign bus.bus_data_out       = r_out;
  assign bus.bus_data_out_valid = r_out_v;
  assign bus.arbiter_split_req  = i_split_req;
  assign bus.split_ack          = i_split_ack;
  assign bus.bus_split_ack      = i_split_ack;
  assign bus.bus_s_ack          = i_wr_ack | r_tx_ack;
  assign bus.bus_s_ready        = i_ready;
  assign bus.bus_s_rw           = bus.s_rw;
  assign bus.last_write         = i_last_write;

endmodule
`default_nettype wire

// File: rtl/split_target.sv
`default_nettype none
// ============================================================================
// Module   : split_target
// Brief    : Byte-wide memory target with immediate writes and split reads.
// Revision : 1.0
// ============================================================================
module split_target
  import split_target_pkg::*;
#(
  parameter int ADDR_WIDTH         = c_addr_width,
  parameter int DATA_WIDTH         = c_data_width,
  parameter int INTERNAL_ADDR_BITS = 12,
  parameter int READ_LATENCY       = 4
) (
  input wire logic      clk,
  input wire logic      rst_n,
  split_target_if.slave bus
);

  localparam int c_lat_w = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [c_lat_w-1:0] c_lat_max = c_lat_w'(READ_LATENCY - 1);

  state_t                        r_state;
  logic [INTERNAL_ADDR_BITS-1:0] r_mem_addr;
  logic [c_lat_w-1:0]            r_lat_cnt;
  logic                          r_ready;
  logic                          r_wr_ack;
  logic                          r_split_ack;
  logic                          r_split_req;
  logic                          r_tx_load;
  logic [DATA_WIDTH-1:0]         r_tx_data;
  logic [DATA_WIDTH-1:0]         r_last_write;
  logic [DATA_WIDTH-1:0]         r_mem [2**INTERNAL_ADDR_BITS];

  logic [ADDR_WIDTH-1:0] w_addr;
  logic                  w_addr_valid;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  w_data_valid;
  logic                  w_tx_done;
  logic                  w_mem_we;
  logic                  w_addr_unused;

  // Upper address bits alias onto the same memory location.
  assign w_addr_unused = ^w_addr[ADDR_WIDTH-1:INTERNAL_ADDR_BITS];

  split_target_port #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_port (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .i_ready      (r_ready),
    .i_wr_ack     (r_wr_ack),
    .i_split_ack  (r_split_ack),
    .i_split_req  (r_split_req),
    .i_tx_load    (r_tx_load),
    .i_tx_data    (r_tx_data),
    .i_last_write (r_last_write),
    .o_addr       (w_addr),
    .o_addr_valid (w_addr_valid),
    .o_data       (w_data),
    .o_data_valid (w_data_valid),
    .o_tx_done    (w_tx_done)
  );

  assign w_mem_we = (r_state == S_WAIT_DATA) && w_data_valid;

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[r_mem_addr] <= w_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_mem_addr   <= '0;
      r_lat_cnt    <= '0;
      r_ready      <= 1'b0;
      r_wr_ack     <= 1'b0;
      r_split_ack  <= 1'b0;
      r_split_req  <= 1'b0;
      r_tx_load    <= 1'b0;
      r_tx_data    <= '0;
      r_last_write <= '0;
    end else begin
      r_wr_ack    <= 1'b0;
      r_split_ack <= 1'b0;
      r_tx_load   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_ready <= 1'b1;
          if (w_addr_valid) begin
            r_mem_addr <= w_addr[INTERNAL_ADDR_BITS-1:0];
            if (bus.s_rw) begin
              r_state <= S_WAIT_DATA;
            end else begin
              r_split_ack <= 1'b1;
              r_ready     <= 1'b0;
              r_lat_cnt   <= '0;
              r_state     <= S_READ_WAIT;
            end
          end
        end
        S_WAIT_DATA: begin
          if (w_data_valid) begin
            r_last_write <= w_data;
            r_wr_ack     <= 1'b1;
            r_ready      <= 1'b0;
            r_state      <= S_WRITE;
          end
        end
        S_WRITE: begin
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
        S_READ_WAIT: begin
          if (r_lat_cnt == c_lat_max) begin
            r_split_req <= 1'b1;
            r_state     <= S_SPLIT_REQ;
          end else begin
            r_lat_cnt <= r_lat_cnt + 1'b1;
          end
        end
        S_SPLIT_REQ: begin
          if (bus.split_grant) begin
            r_split_req <= 1'b0;
            r_tx_data   <= r_mem[r_mem_addr];
            r_tx_load   <= 1'b1;
            r_state     <= S_SEND;
          end
        end
        S_SEND: begin
          if (w_tx_done) begin
            r_ready <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_ready <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_split_target.sv
`default_nettype none
// ============================================================================
// Module   : tb_split_target
// Brief    : Table-driven, scoreboarded bench for split_target with arbiter model.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_split_target;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  split_target_if bus();

  split_target #(
    .ADDR_WIDTH         (16),
    .DATA_WIDTH         (8),
    .INTERNAL_ADDR_BITS (12),
    .READ_LATENCY       (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        rw;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  exp_rd;
    logic [7:0]  exp_lw;
  } vec_t;

  int checks = 0;
  int failures = 0;
  int wr_acks = 0;
  int rd_acks = 0;
  int split_acks = 0;
  int cyc = 0;
  int split_cyc = 0;
  int req_rise_lat = 0;
  int req_cnt = 0;
  int last_req_cycles = 0;
  int grant_delay = 2;
  logic req_prev = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  int rx_n = 0;
  logic [7:0] exp_q[$];
  vec_t vecs[9];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor and arbiter share one sampling point so grant timing is deterministic.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      rx_n = 0;
      req_cnt = 0;
      req_prev = 1'b0;
      bus.split_grant = 1'b0;
    end else begin
      if (bus.split_ack) begin
        split_acks++;
        split_cyc = cyc;
        check("bus_split_ack", int'(bus.bus_split_ack), 1);
      end
      if (bus.arbiter_split_req && !req_prev) req_rise_lat = cyc - split_cyc;
      if (bus.bus_s_ack) begin
        if (bus.bus_s_rw) wr_acks++;
        else begin
          rd_acks++;
          check("rd_ack_on_bit7", (bus.bus_data_out_valid && rx_n == 7) ? 1 : 0, 1);
        end
      end
      if (bus.bus_data_out_valid) begin
        rx_byte[rx_n] = bus.bus_data_out;
        rx_n++;
        if (rx_n == 8) begin
          rx_n = 0;
          if (exp_q.size() == 0) check("rd_unexpected", int'(rx_byte), -1);
          else check("rd_data", int'(rx_byte), int'(exp_q.pop_front()));
        end
      end
      if (bus.split_grant) begin
        bus.split_grant = 1'b0;
        last_req_cycles = req_cnt;
        req_cnt = 0;
      end else if (bus.arbiter_split_req) begin
        req_cnt++;
        if (req_cnt >= grant_delay) bus.split_grant = 1'b1;
      end
      req_prev = bus.arbiter_split_req;
    end
  end

  task automatic send_bits(input logic [15:0] v, input int n, input logic mode, input logic dec);
    bus.decoder_valid = dec;
    bus.bus_mode = mode;
    for (int i = 0; i < n; i++) begin
      bus.bus_data_in = v[i];
      bus.bus_data_in_valid = 1'b1;
      @(negedge clk);
    end
    bus.bus_data_in_valid = 1'b0;
    bus.bus_data_in = 1'b0;
  endtask

  task automatic do_txn(input vec_t v);
    int a0, s0, t;
    a0 = wr_acks + rd_acks;
    s0 = split_acks;
    t = 0;
    while (!bus.bus_s_ready && t < 200) begin @(negedge clk); t++; end
    check("ready_before_txn", int'(bus.bus_s_ready), 1);
    bus.s_rw = v.rw;
    if (!v.rw) exp_q.push_back(v.exp_rd);
    send_bits(v.addr, 16, 1'b0, 1'b1);
    if (v.rw) send_bits({8'h00, v.wdata}, 8, 1'b1, 1'b1);
    bus.decoder_valid = 1'b0;
    t = 0;
    while ((wr_acks + rd_acks) == a0 && t < 200) begin @(negedge clk); t++; end
    repeat (3) @(negedge clk);
    check("ack_count", wr_acks + rd_acks - a0, 1);
    check("split_count", split_acks - s0, v.rw ? 0 : 1);
    check("last_write", int'(bus.last_write), int'(v.exp_lw));
    if (!v.rw) begin
      check("req_latency", req_rise_lat, 4);
      check("req_hold", last_req_cycles, grant_delay);
    end
  endtask

  initial begin
    int a0, s0;
    vec_t v;
    bus.decoder_valid = 1'b0;
    bus.bus_data_in = 1'b0;
    bus.bus_data_in_valid = 1'b0;
    bus.bus_mode = 1'b0;
    bus.s_rw = 1'b0;
    bus.split_grant = 1'b0;

    vecs[0] = '{1'b1, 16'h8F20, 8'hC5, 8'h00, 8'hC5};
    vecs[1] = '{1'b0, 16'h8F20, 8'h00, 8'hC5, 8'hC5};
    vecs[2] = '{1'b1, 16'h0123, 8'hA5, 8'h00, 8'hA5};
    vecs[3] = '{1'b0, 16'hF123, 8'h00, 8'hA5, 8'hA5};
    vecs[4] = '{1'b1, 16'h0FFF, 8'h3C, 8'h00, 8'h3C};
    vecs[5] = '{1'b0, 16'hFFFF, 8'h00, 8'h3C, 8'h3C};
    vecs[6] = '{1'b1, 16'h0000, 8'h81, 8'h00, 8'h81};
    vecs[7] = '{1'b0, 16'h1000, 8'h00, 8'h81, 8'h81};
    vecs[8] = '{1'b0, 16'h8F20, 8'h00, 8'hC5, 8'h81};

    repeat (3) @(negedge clk);
    check("rst_ready", int'(bus.bus_s_ready), 0);
    check("rst_ack", int'(bus.bus_s_ack), 0);
    check("rst_dout_valid", int'(bus.bus_data_out_valid), 0);
    check("rst_split_req", int'(bus.arbiter_split_req), 0);
    check("rst_last_write", int'(bus.last_write), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_ready", int'(bus.bus_s_ready), 1);

    for (int i = 0; i < 9; i++) begin
      do_txn(vecs[i]);
      if (i == 1) begin
        check("total_wr_acks", wr_acks, 1);
        check("total_rd_acks", rd_acks, 1);
        check("total_split_acks", split_acks, 1);
      end
    end

    // Address bits with the decoder deselected must be ignored entirely.
    a0 = wr_acks + rd_acks;
    s0 = split_acks;
    bus.s_rw = 1'b0;
    send_bits(16'h8F20, 16, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    check("nodec_acks", wr_acks + rd_acks - a0, 0);
    check("nodec_split", split_acks - s0, 0);
    check("nodec_ready", int'(bus.bus_s_ready), 1);

    grant_delay = 10;
    v = '{1'b0, 16'h8F20, 8'h00, 8'hC5, 8'h81};
    do_txn(v);
    grant_delay = 2;

    // Reset while the read is waiting on its internal latency.
    a0 = wr_acks + rd_acks;
    bus.s_rw = 1'b0;
    send_bits(16'h0123, 16, 1'b0, 1'b1);
    bus.decoder_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_ready", int'(bus.bus_s_ready), 0);
    check("midrst_split_ack", int'(bus.split_ack), 0);
    check("midrst_split_req", int'(bus.arbiter_split_req), 0);
    check("midrst_dout_valid", int'(bus.bus_data_out_valid), 0);
    check("midrst_ack", int'(bus.bus_s_ack), 0);
    check("midrst_last_write", int'(bus.last_write), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("midrst_no_ack", wr_acks + rd_acks - a0, 0);
    v = '{1'b1, 16'h0456, 8'h5A, 8'h00, 8'h5A};
    do_txn(v);
    v = '{1'b0, 16'hF456, 8'h00, 8'h5A, 8'h5A};
    do_txn(v);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/split_target.md
Name: split_target

Overview:
- Split-capable bus target: a serial-bus port adapter plus a byte-wide memory target that supports split reads.
- Deserializes address and write data from the 1-bit system bus and performs writes immediately.
- Reads are split: the target acknowledges the split, releases the bus, waits its internal read latency, requests the bus back from the arbiter, then serializes the read byte onto the bus.

Parameters:
- ADDR_WIDTH, 16, bus address width (serial address field length).
- DATA_WIDTH, 8, data width (serial data field length).
- INTERNAL_ADDR_BITS, 12, memory index bits; upper address bits ignored; memory depth 2^INTERNAL_ADDR_BITS bytes.
- READ_LATENCY, 4, cycles from read-address capture to split_req assertion.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- decoder_valid  in  1  target selected by address decoder; serial input is ignored when low.
- bus_data_in  in  1  serial bit, LSB first.
- bus_data_in_valid  in  1  bus_data_in qualifier.
- bus_mode  in  1  0 = address bit, 1 = write-data bit.
- s_rw  in  1  transaction type: 1 = write, 0 = read; held stable for the whole transaction.
- split_grant  in  1  one-cycle arbiter grant answering split_req.
- bus_data_out  out  1  serial read data, LSB first.
- bus_data_out_valid  out  1  bus_data_out qualifier.
- arbiter_split_req  out  1  request to re-own the bus for split completion.
- split_ack  out  1  split acknowledge, to the arbiter.
- bus_split_ack  out  1  split acknowledge, to the bus; equal to split_ack.
- bus_s_ack  out  1  transaction-complete pulse.
- bus_s_ready  out  1  target idle and able to accept a transaction.
- bus_s_rw  out  1  combinational copy of s_rw.
- last_write  out  8  last byte written; reset 0.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; shift counters cleared. Memory contents are not reset. Reset asserted mid-transaction aborts it with no ack.
- Port deserializer:
  - A bit is accepted when bus_data_in_valid && decoder_valid && bus_s_ready.
  - mode 0 bits shift into a 16-bit address register, bit i at position i. On the 16th bit, an internal addr_valid pulses for one cycle.
  - mode 1 bits fill the 8-bit data register. On the 8th bit, data_valid pulses.
  - Counters clear on decoder_valid low and after each completed field.
- Core FSM states: IDLE, WAIT_DATA, WRITE, READ_WAIT, SPLIT_REQ, SEND.
- IDLE: bus_s_ready=1. On addr_valid, latch addr[INTERNAL_ADDR_BITS-1:0].
  - s_rw=1: go to WAIT_DATA.
  - s_rw=0: pulse split_ack and bus_split_ack for exactly one cycle (the cycle after capture), drop ready, go to READ_WAIT.
- WAIT_DATA: on data_valid, go to WRITE.
- WRITE (1 cycle): mem[addr] <= data; last_write <= data; bus_s_ack=1 for one cycle; return to IDLE.
- READ_WAIT: count READ_LATENCY cycles, then go to SPLIT_REQ.
- SPLIT_REQ: arbiter_split_req held high until split_grant is sampled high. Then drop the request, load mem[addr] into the output shifter, go to SEND.
- split_grant outside SPLIT_REQ is ignored.
- SEND: 8 consecutive cycles with bus_data_out_valid=1, bits LSB first. bus_s_ack=1 in the cycle carrying bit 7, with bus_s_rw low (read). Then return to IDLE.
- Serial input arriving while not IDLE/WAIT_DATA is dropped.
- bus_s_ready is low in all states except IDLE and WAIT_DATA.
- Exactly one ack per transaction; exactly one split_ack per read; none for writes.

Decomposition:
- Shared package: ADDR_WIDTH, DATA_WIDTH constants; FSM state enum.
- Sub-module split_target_port: serializer/deserializer, pass-through of ready/ack/split signals.
- Core FSM and memory inline in split_target.

Test Plan:
- Write: s_rw=1, address 0x8F20, data 0xC5 -> one bus_s_ack with bus_s_rw=1, last_write=0xC5, no split_ack.
- Read back 0x8F20 (arbiter grants 2 cycles after request):
  - one split_ack pulse;
  - arbiter_split_req rises 4 cycles later and holds until grant;
  - 8 valid bits reassemble to 0xC5;
  - one read ack;
  - totals: write_ack=1, read_ack=1, split_ack=1.
- Aliasing: write 0xA5 to 0x0123, read 0xF123 -> 0xA5 (upper address bits ignored).
- decoder_valid=0 during a full 16-bit address -> no ack, no split_ack, FSM stays IDLE.
- Delayed grant (10 cycles) -> arbiter_split_req stays high throughout; data and ack follow the grant.
- rst_n pulsed during READ_WAIT -> all outputs 0 and no ack; a following write/read completes normally.
